// File: rtl/uno_seq.sv
// Sequencer for the uno PE: accepts one request at a time, issues it to the PE
// (one MAC cycle or an N_TERMS+1 polynomial walk), waits MAC_LAT cycles and holds the result.
module uno_seq #(
  parameter int BW      = 12,
  parameter int N_TERMS = 4,
  parameter int MAC_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [BW-1:0]   in_x,
  input  logic [BW-1:0]   in_y,
  input  logic [2*BW-1:0] in_z,
  input  logic            in_acc,
  input  logic            coef_we,
  input  logic [1:0]      coef_op,
  input  logic [2:0]      coef_idx,
  input  logic [BW-1:0]   coef_data,
  output logic [1:0]      uno_op,
  output logic [BW-1:0]   uno_x,
  output logic [BW-1:0]   uno_y,
  output logic [2*BW-1:0] uno_z,
  output logic [BW-1:0]   uno_coeff,
  output logic            uno_first_cycle,
  output logic            uno_last_cycle,
  output logic            uno_acc_en,
  input  logic [2*BW-1:0] uno_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*BW-1:0] out_data,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam int KW = 4;
  localparam int WW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic [BW-1:0]     r_x, r_y;
  logic [2*BW-1:0]   r_z;
  logic              r_acc;
  logic [KW-1:0]     r_k;
  logic [WW-1:0]     r_wcnt;
  logic [2*BW-1:0]   r_out;
  logic [BW-1:0]     r_coef [3][N_TERMS];

  logic              w_accept;
  logic              w_issue_done;
  logic              w_wait_done;
  logic [KW-1:0]     w_tidx;
  logic [BW-1:0]     w_coef;

  assign w_accept     = (r_state == IDLE) && in_valid;
  assign w_issue_done = (r_state == ISSUE) && ((r_op == 2'b00) || (r_k == KW'(N_TERMS)));
  assign w_wait_done  = (r_state == WAIT) && (r_wcnt == WW'(MAC_LAT - 1));
  // Terms are walked highest index first; at k==N_TERMS this wraps past every
  // valid index so the lookup below falls through to zero.
  assign w_tidx       = KW'(N_TERMS - 1) - r_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_acc  <= 1'b0;
      r_k    <= '0;
      r_wcnt <= '0;
      r_out  <= '0;
      for (int unsigned j = 0; j < 3; j++)
        for (int unsigned i = 0; i < N_TERMS; i++)
          r_coef[j][i] <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= in_op;
        r_x   <= in_x;
        r_y   <= in_y;
        r_z   <= in_z;
        r_acc <= in_acc;
      end
      r_k    <= (r_state == ISSUE) ? r_k + KW'(1) : '0;
      r_wcnt <= (r_state == WAIT) ? r_wcnt + WW'(1) : '0;
      if (w_wait_done) r_out <= uno_result;
      // Only indices below N_TERMS match, so out-of-range writes drop out naturally.
      for (int unsigned j = 0; j < 3; j++)
        for (int unsigned i = 0; i < N_TERMS; i++)
          if ((r_state == IDLE) && coef_we && (coef_op == 2'(j + 1)) && (coef_idx == 3'(i)))
            r_coef[j][i] <= coef_data;
    end
  end

  always_comb begin
    w_coef = '0;
    for (int unsigned j = 0; j < 3; j++)
      for (int unsigned i = 0; i < N_TERMS; i++)
        if ((r_op == 2'(j + 1)) && (w_tidx == KW'(i)))
          w_coef = r_coef[j][i];
  end

  always_comb begin
    w_next          = r_state;
    uno_op          = '0;
    uno_x           = '0;
    uno_y           = '0;
    uno_z           = '0;
    uno_coeff       = '0;
    uno_first_cycle = 1'b0;
    uno_last_cycle  = 1'b0;
    uno_acc_en      = 1'b0;
    case (r_state)
      IDLE:  if (w_accept) w_next = ISSUE;
      ISSUE: begin
        uno_op = r_op;
        uno_x  = r_x;
        uno_y  = r_y;
        uno_z  = r_z;
        if (r_op == 2'b00) begin
          uno_acc_en = r_acc;
        end else begin
          uno_coeff       = w_coef;
          uno_first_cycle = (r_k == '0);
          uno_last_cycle  = (r_k == KW'(N_TERMS));
        end
        if (w_issue_done) w_next = WAIT;
      end
      WAIT:  if (w_wait_done) w_next = HOLD;
      HOLD:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq: MAC, exp walk, backpressure, busy-time coefficient writes, reset abort.
module tb_uno_seq;

  localparam int BW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [1:0]      in_op;
  logic [BW-1:0]   in_x, in_y;
  logic [2*BW-1:0] in_z;
  logic            in_acc;
  logic            coef_we;
  logic [1:0]      coef_op;
  logic [2:0]      coef_idx;
  logic [BW-1:0]   coef_data;
  logic [1:0]      uno_op;
  logic [BW-1:0]   uno_x, uno_y, uno_coeff;
  logic [2*BW-1:0] uno_z, uno_result, out_data;
  logic            uno_first_cycle, uno_last_cycle, uno_acc_en;
  logic            out_valid, out_ready, busy;

  int n_tot = 0;
  int n_bad = 0;

  uno_seq #(.BW(BW), .N_TERMS(4), .MAC_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_acc(in_acc),
    .coef_we(coef_we), .coef_op(coef_op), .coef_idx(coef_idx), .coef_data(coef_data),
    .uno_op(uno_op), .uno_x(uno_x), .uno_y(uno_y), .uno_z(uno_z), .uno_coeff(uno_coeff),
    .uno_first_cycle(uno_first_cycle), .uno_last_cycle(uno_last_cycle), .uno_acc_en(uno_acc_en),
    .uno_result(uno_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [1:0] op, input logic [2:0] idx, input logic [BW-1:0] d);
    coef_we = 1'b1; coef_op = op; coef_idx = idx; coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic req(input logic [1:0] op, input logic [BW-1:0] x, input logic [BW-1:0] y,
                     input logic [2*BW-1:0] z, input logic acc);
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_z = z; in_acc = acc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; in_z = '0; in_acc = 1'b0;
    coef_we = 1'b0; coef_op = '0; coef_idx = '0; coef_data = '0;
    uno_result = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_uno_x", uno_x, 0);
    rst = 1'b0;

    // MAC: accept at edge 0, issue in cycle 1, result in cycle 3
    uno_result = 24'h000026;
    req(2'b00, 12'd3, 12'd5, 24'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mac_c1_x", uno_x, 3);
    chk("mac_c1_y", uno_y, 5);
    chk("mac_c1_z", uno_z, 7);
    chk("mac_c1_coeff", uno_coeff, 0);
    chk("mac_c1_flags", {uno_first_cycle, uno_last_cycle, uno_acc_en}, 0);
    chk("mac_c1_ready", in_ready, 0);
    tick();
    chk("mac_c2_x", uno_x, 0);
    chk("mac_c2_ov", out_valid, 0);
    tick();
    chk("mac_c3_ov", out_valid, 1);
    chk("mac_c3_data", out_data, 32'h26);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mac_done_ready", in_ready, 1);

    // MAC with accumulate flag
    req(2'b00, 12'd1, 12'd1, 24'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("macacc_en", uno_acc_en, 1);
    tick(); tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Exp: last coefficient write lands in the same cycle as the accept
    wr_coef(2'b10, 3'd0, 12'h010);
    wr_coef(2'b10, 3'd1, 12'h020);
    wr_coef(2'b10, 3'd2, 12'h030);
    coef_we = 1'b1; coef_op = 2'b10; coef_idx = 3'd3; coef_data = 12'h040;
    uno_result = 24'h0ABCDE;
    req(2'b10, 12'h00A, 12'h00B, 24'd0, 1'b0);
    tick();
    coef_we = 1'b0; in_valid = 1'b0;
    begin
      logic [BW-1:0] exp_c [5];
      exp_c = '{12'h040, 12'h030, 12'h020, 12'h010, 12'h000};
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("exp_coeff_k%0d", k), uno_coeff, exp_c[k]);
        chk($sformatf("exp_first_k%0d", k), uno_first_cycle, (k == 0));
        chk($sformatf("exp_last_k%0d", k), uno_last_cycle, (k == 4));
        chk($sformatf("exp_op_k%0d", k), uno_op, 2'b10);
        tick();
      end
    end
    chk("exp_c6_ov", out_valid, 0);
    chk("exp_c6_op", uno_op, 0);
    tick();
    chk("exp_c7_ov", out_valid, 1);
    chk("exp_c7_data", out_data, 32'h0ABCDE);

    // Backpressure, with a stray request that must not be queued
    uno_result = 24'h111111;
    req(2'b00, 12'd9, 12'd9, 24'd9, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp_data_%0d", c), out_data, 32'h0ABCDE);
      chk($sformatf("bp_ready_%0d", c), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_ov", out_valid, 0);
    tick();
    chk("bp_not_queued", busy, 0);

    // Busy-time write to div table must be ignored; coef_op=00 and idx>=N_TERMS too
    wr_coef(2'b01, 3'd0, 12'h111);
    wr_coef(2'b01, 3'd3, 12'h444);
    req(2'b01, 12'd2, 12'd3, 24'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("div1_k0", uno_coeff, 12'h444);
    wr_coef(2'b01, 3'd0, 12'hFFF);
    tick(); tick();
    chk("div1_k3", uno_coeff, 12'h111);
    tick(); tick(); tick();
    chk("div1_ov", out_valid, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    wr_coef(2'b00, 3'd0, 12'hABC);
    wr_coef(2'b01, 3'd4, 12'hEEE);
    req(2'b01, 12'd2, 12'd3, 24'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("div2_k0", uno_coeff, 12'h444);
    tick(); tick(); tick();
    chk("div2_k3", uno_coeff, 12'h111);
    tick(); tick(); tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset at k=2 of a log op
    wr_coef(2'b11, 3'd1, 12'h055);
    req(2'b11, 12'd9, 12'd4, 24'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("log_k2_coeff", uno_coeff, 12'h055);
    chk("log_k2_x", uno_x, 9);
    rst = 1'b1;
    #1;
    chk("abort_x", uno_x, 0);
    chk("abort_op", uno_op, 0);
    chk("abort_coeff", uno_coeff, 0);
    chk("abort_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    uno_result = 24'h000077;
    req(2'b00, 12'd6, 12'd7, 24'd8, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_x", uno_x, 6);
    chk("post_rst_ov1", out_valid, 0);
    tick();
    chk("post_rst_ov2", out_valid, 0);
    tick();
    chk("post_rst_ov3", out_valid, 1);
    chk("post_rst_data", out_data, 32'h77);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Table cleared by reset
    req(2'b11, 12'd1, 12'd1, 24'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_cleared_coef", uno_coeff, 0);
    tick(); tick(); tick(); tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
